// File: rtl/ysyx_22040088_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state encoding,
// requester IDs and default bus widths.
package ysyx_22040088_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned MASK_W     = 8;

  // Requester IDs; also the bit positions inside the one-hot grant vector.
  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_22040088_mem_arb_if.sv
// Bus bundle around the memory arbiter.
//   if_*  : instruction fetch request/response (read-only)
//   lsu_* : load/store request/response
//   mem_* : single shared memory port
// slave  = arbiter side, master = environment side (IFU/LSU/memory model).
interface ysyx_22040088_mem_arb_if
  import ysyx_22040088_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22040088_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   valid      : request valids, indexed by REQ_IF / REQ_LSU
//   last_grant : requester served most recently
//   enable     : no grant is issued when low
//   grant      : one-hot grant (all zero when nothing is granted)
module ysyx_22040088_rr_arb2
  import ysyx_22040088_mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        if (last_grant == REQ_LSU) grant[REQ_IF]  = 1'b1;
        else                       grant[REQ_LSU] = 1'b1;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040088_mem_arb.sv
// Shares one memory port between IFU (read-only) and LSU (read/write).
// One transaction outstanding at a time, round-robin on ties, with a
// response watchdog that turns a hung memory into an error response.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : IF/LSU request/response and memory port (slave modport)
//   busy     : arbiter is not idle
module ysyx_22040088_mem_arb
  import ysyx_22040088_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22040088_mem_arb_if.slave bus,
  output logic                   busy
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              if_resp_valid_q, if_resp_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_resp_err_q, if_resp_err_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              lsu_resp_err_q, lsu_resp_err_d;
  logic              busy_q, busy_d;
  logic [1:0]        grant;

  // Requests are only accepted while idle.
  ysyx_22040088_rr_arb2 u_rr_arb2 (
    .valid      ({bus.lsu_req_valid, bus.if_req_valid}),
    .last_grant (last_grant_q),
    .enable     (state_q == ST_IDLE),
    .grant      (grant)
  );

  // Next-state, payload capture, watchdog and response generation.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_wen_d        = mem_wen_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wmask_d      = mem_wmask_q;
    if_resp_valid_d  = 1'b0;
    if_rdata_d       = if_rdata_q;
    if_resp_err_d    = if_resp_err_q;
    lsu_resp_valid_d = 1'b0;
    lsu_rdata_d      = lsu_rdata_q;
    lsu_resp_err_d   = lsu_resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d         = grant[REQ_LSU];
          last_grant_d    = grant[REQ_LSU];
          mem_req_valid_d = 1'b1;
          state_d         = ST_REQ;
          if (grant[REQ_LSU]) begin
            mem_addr_d  = bus.lsu_addr;
            mem_wen_d   = bus.lsu_wen;
            mem_wdata_d = bus.lsu_wdata;
            mem_wmask_d = bus.lsu_wmask;
          end else begin
            // Fetches are always reads.
            mem_addr_d  = bus.if_addr;
            mem_wen_d   = 1'b0;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end
        end
      end

      ST_REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A real response beats a watchdog expiry in the same cycle.
        if (bus.mem_resp_valid || (WDOG_EN && cnt_q == CNT_W'(TO_LAST))) begin
          state_d = ST_RESP;
          if (owner_q == REQ_LSU) begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = (bus.mem_resp_valid && !mem_wen_q) ? bus.mem_rdata : '0;
            lsu_resp_err_d   = !bus.mem_resp_valid;
          end else begin
            if_resp_valid_d  = 1'b1;
            if_rdata_d       = bus.mem_resp_valid ? bus.mem_rdata : '0;
            if_resp_err_d    = !bus.mem_resp_valid;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      last_grant_q     <= REQ_LSU;
      owner_q          <= REQ_IF;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_wen_q        <= 1'b0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      if_resp_valid_q  <= 1'b0;
      if_rdata_q       <= '0;
      if_resp_err_q    <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_resp_err_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      last_grant_q     <= last_grant_d;
      owner_q          <= owner_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_wen_q        <= mem_wen_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wmask_q      <= mem_wmask_d;
      if_resp_valid_q  <= if_resp_valid_d;
      if_rdata_q       <= if_rdata_d;
      if_resp_err_q    <= if_resp_err_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_rdata_q      <= lsu_rdata_d;
      lsu_resp_err_q   <= lsu_resp_err_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.if_req_ready   = grant[REQ_IF];
  assign bus.lsu_req_ready  = grant[REQ_LSU];
  assign bus.if_resp_valid  = if_resp_valid_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.if_resp_err    = if_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wmask      = mem_wmask_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_ysyx_22040088_mem_arb.sv
// Directed self-checking bench for the IFU/LSU memory arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_22040088_mem_arb;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   passed;

  ysyx_22040088_mem_arb_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22040088_mem_arb #(
    .ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_addr        = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: got %b want 0", bus.mem_req_valid); else passed++;
    total++; if (bus.mem_addr !== 64'h0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    total++; if ({bus.if_resp_valid, bus.lsu_resp_valid, bus.if_resp_err, bus.lsu_resp_err} !== 4'b0000)
      $display("FAIL reset_resp_flags: got %b want 0000", {bus.if_resp_valid, bus.lsu_resp_valid, bus.if_resp_err, bus.lsu_resp_err});
    else passed++;
    total++; if ({bus.if_req_ready, bus.lsu_req_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {bus.if_req_ready, bus.lsu_req_ready}); else passed++;
  endtask

  task automatic test_if_read();
    // Cycle T: handshake.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h8000_0000;
    #1;
    total++; if ({bus.lsu_req_ready, bus.if_req_ready} !== 2'b01) $display("FAIL if_read_ready: got %b want 01", {bus.lsu_req_ready, bus.if_req_ready}); else passed++;
    // T+1: request presented to memory.
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 64'h8000_0000 || bus.mem_wen !== 1'b0)
      $display("FAIL if_read_mem_req: got v=%b a=%h w=%b want v=1 a=80000000 w=0", bus.mem_req_valid, bus.mem_addr, bus.mem_wen);
    else passed++;
    total++; if (busy !== 1'b1) $display("FAIL if_read_busy: got %b want 1", busy); else passed++;
    bus.mem_req_ready = 1'b1;
    // T+2: waiting, memory answers.
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h0000_0413;
    total++; if (bus.if_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
      $display("FAIL if_read_wait: got rv=%b mv=%b want 0 0", bus.if_resp_valid, bus.mem_req_valid);
    else passed++;
    // T+3: response pulse.
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    total++; if (bus.if_resp_valid !== 1'b1 || bus.if_rdata !== 64'h413 || bus.if_resp_err !== 1'b0)
      $display("FAIL if_read_resp: got v=%b d=%h e=%b want 1 413 0", bus.if_resp_valid, bus.if_rdata, bus.if_resp_err);
    else passed++;
    total++; if (bus.lsu_resp_valid !== 1'b0) $display("FAIL if_read_lsu_quiet: got %b want 0", bus.lsu_resp_valid); else passed++;
    // T+4: back to idle, data held.
    @(negedge clk);
    total++; if (bus.if_resp_valid !== 1'b0 || busy !== 1'b0 || bus.if_rdata !== 64'h413)
      $display("FAIL if_read_after: got v=%b busy=%b d=%h want 0 0 413", bus.if_resp_valid, busy, bus.if_rdata);
    else passed++;
  endtask

  task automatic test_lsu_store();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 64'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 64'hDEAD_BEEF;
    bus.lsu_wmask     = 8'h0F;
    #1;
    total++; if ({bus.lsu_req_ready, bus.if_req_ready} !== 2'b10) $display("FAIL store_ready: got %b want 10", {bus.lsu_req_ready, bus.if_req_ready}); else passed++;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen       = 1'b0;
    total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_addr !== 64'h8000_1000 ||
                 bus.mem_wdata !== 64'hDEAD_BEEF || bus.mem_wmask !== 8'h0F)
      $display("FAIL store_mem_fields: got v=%b w=%b a=%h d=%h m=%h", bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    else passed++;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h1234_5678; // must be discarded for a store
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    total++; if (bus.lsu_resp_valid !== 1'b1 || bus.lsu_rdata !== 64'h0 || bus.lsu_resp_err !== 1'b0)
      $display("FAIL store_resp: got v=%b d=%h e=%b want 1 0 0", bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err);
    else passed++;
    total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL store_if_quiet: got %b want 0", bus.if_resp_valid); else passed++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_addr;
    logic        exp_lsu;
    apply_reset();
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = 64'h8000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 64'h8000_2200;
    bus.lsu_wen       = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_lsu  = k[0];
      exp_addr = exp_lsu ? 64'h8000_2200 : 64'h8000_0100;
      #1;
      total++; if ({bus.lsu_req_ready, bus.if_req_ready} !== (exp_lsu ? 2'b10 : 2'b01))
        $display("FAIL rr_grant_%0d: got %b want %b", k, {bus.lsu_req_ready, bus.if_req_ready}, exp_lsu ? 2'b10 : 2'b01);
      else passed++;
      @(negedge clk);
      total++; if (bus.mem_addr !== exp_addr || {bus.lsu_req_ready, bus.if_req_ready} !== 2'b00)
        $display("FAIL rr_req_%0d: got a=%h rdy=%b want a=%h rdy=00", k, bus.mem_addr, {bus.lsu_req_ready, bus.if_req_ready}, exp_addr);
      else passed++;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 64'hA000 + 64'(k);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      total++; if ({bus.lsu_resp_valid, bus.if_resp_valid} !== (exp_lsu ? 2'b10 : 2'b01) ||
                   {bus.lsu_req_ready, bus.if_req_ready} !== 2'b00)
        $display("FAIL rr_resp_%0d: got rv=%b rdy=%b want rv=%b rdy=00", k, {bus.lsu_resp_valid, bus.if_resp_valid},
                 {bus.lsu_req_ready, bus.if_req_ready}, exp_lsu ? 2'b10 : 2'b01);
      else passed++;
      @(negedge clk);
    end
    bus.if_req_valid  = 1'b0;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    // Memory accepts but never answers.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h8000_0040;
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      n++;
    end while (bus.if_resp_valid !== 1'b1 && n < 40);
    total++; if (n !== 9) $display("FAIL timeout_latency: got %0d negedges want 9", n); else passed++;
    total++; if (bus.if_resp_valid !== 1'b1 || bus.if_resp_err !== 1'b1 || bus.if_rdata !== 64'h0)
      $display("FAIL timeout_resp: got v=%b e=%b d=%h want 1 1 0", bus.if_resp_valid, bus.if_resp_err, bus.if_rdata);
    else passed++;
    @(negedge clk);
    // Following LSU load completes normally.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 64'h8000_3000;
    bus.lsu_wen       = 1'b0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'hCAFE;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    total++; if (bus.lsu_resp_valid !== 1'b1 || bus.lsu_resp_err !== 1'b0 || bus.lsu_rdata !== 64'hCAFE)
      $display("FAIL post_timeout_load: got v=%b e=%b d=%h want 1 0 cafe", bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_rdata);
    else passed++;
    @(negedge clk);
    // Response arriving in the final watchdog cycle wins.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h8000_0080;
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      if (k == 8) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h5555;
      end
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    total++; if (bus.if_resp_valid !== 1'b1 || bus.if_resp_err !== 1'b0 || bus.if_rdata !== 64'h5555)
      $display("FAIL timeout_tie: got v=%b e=%b d=%h want 1 0 5555", bus.if_resp_valid, bus.if_resp_err, bus.if_rdata);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_stall_and_reset();
    int bad;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 64'h8000_4000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 64'h0123_4567_89AB_CDEF;
    bus.lsu_wmask     = 8'hFF;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = 64'h8000_0000;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_resp_valid = (k == 2); // stray response while still in REQ
      #1;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 64'h8000_4000 || bus.mem_wdata !== 64'h0123_4567_89AB_CDEF ||
          bus.if_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0 || bus.lsu_resp_valid !== 1'b0)
        bad++;
      @(negedge clk);
    end
    bus.mem_resp_valid = 1'b0;
    total++; if (bad !== 0) $display("FAIL stall_stable: got %0d bad cycles want 0", bad); else passed++;
    total++; if (bus.mem_req_valid !== 1'b1) $display("FAIL stall_still_req: got %b want 1", bus.mem_req_valid); else passed++;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.if_req_valid  = 1'b0;
    total++; if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0) $display("FAIL stall_wait: got busy=%b v=%b want 1 0", busy, bus.mem_req_valid); else passed++;
    // Reset while waiting for memory.
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0 ||
                 bus.mem_wen !== 1'b0 || bus.mem_wmask !== 8'h0)
      $display("FAIL rst_in_wait_mem: got busy=%b v=%b a=%h d=%h w=%b m=%h", busy, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wen, bus.mem_wmask);
    else passed++;
    total++; if ({bus.if_resp_valid, bus.lsu_resp_valid} !== 2'b00 || bus.if_rdata !== 64'h0 || bus.lsu_rdata !== 64'h0)
      $display("FAIL rst_in_wait_resp: got rv=%b ifd=%h lsd=%h want 00 0 0", {bus.if_resp_valid, bus.lsu_resp_valid}, bus.if_rdata, bus.lsu_rdata);
    else passed++;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; // late answer to the dropped transaction
    bus.mem_rdata      = 64'h7777;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (bus.if_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rst_no_pulse: got %0d bad cycles want 0", bad); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_lsu_store();
    test_round_robin();
    test_timeout();
    test_stall_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
